pipe5_core_param: RTL and testbench
===================================

Name: pipe5_core_param

Overview:
- Parametrised single-clock successor of the 5-stage (IF/ID/EX/MEM/WB) integer pipeline.
- Adds the following over the previous generation:
  - XLEN-generic datapath.
  - External instruction and data memory ports.
  - Full EX forwarding and load-use interlock.
  - Branch flush and a precise HALT.
  - Retirement counter and register-file debug port.
- Sits between the instruction ROM/data RAM wrappers and the test harness.

Parameters:
- XLEN, 32: datapath and register width (16..64).
- IMEM_AW, 10: instruction-memory word-address width. PC is word-addressed.
- DMEM_AW, 10: data-memory word-address width.
- CNT_W, 32: width of the retire counter.

Ports:
- clk          in   1        rising-edge clock
- rst_n        in   1        asynchronous active-low reset
- imem_addr    out  IMEM_AW  fetch address = PC[IMEM_AW-1:0]
- imem_rdata   in   32       instruction at imem_addr, combinational (same cycle)
- dmem_addr    out  DMEM_AW  load/store address = ALU result[DMEM_AW-1:0]
- dmem_wdata   out  XLEN     store data
- dmem_we      out  1        store strobe; memory writes on the clk edge
- dmem_rdata   in   XLEN     load data, combinational from dmem_addr
- halted       out  1        HALT has retired; core frozen
- retire_valid out  1        one instruction retired in WB this cycle
- retire_count out  CNT_W    total retired instructions; wraps modulo 2^CNT_W
- dbg_raddr    in   5        debug register index
- dbg_rdata    out  XLEN     Reg[dbg_raddr], combinational; 0 when index is 0

Behaviour:
- Encoding: op[31:26], rs[25:20..21] = [25:21], rt[20:16], rd[15:11], imm[15:0]. imm is sign-extended to XLEN.
- R-R ops (write rd): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, result 1/0), MUL 000101 (low XLEN bits).
- Immediate ALU ops (write rt): ADDI 001010, SUBI 001011, SLTI 001100.
- Memory ops: LW 001000 (rt <- M[rs+imm]); SW 001001 (M[rs+imm] <- rt).
- Branches: BNEQZ 001101 and BEQZ 001110 test rs. Target = PC_of_branch + 1 + imm.
- HALT 111111.
- Any other opcode executes as a NOP and still retires.
- Reset (async, rst_n=0):
  - PC=0; all stage valid bits=0; Reg[0..31]=0.
  - halted=0, retire_count=0, retire_valid=0, dmem_we=0.
  - Takes effect mid-instruction with no drain.
- Throughput: one instruction per cycle absent hazards. Result is visible in the register file at the WB edge, 5 cycles after fetch.
- Register file:
  - R0 reads 0 and ignores writes.
  - ID reads bypass a same-cycle WB write, so write-through.
- Forwarding to EX operands:
  - Priority is EX/MEM ALU result first, then MEM/WB (ALU result or load data), then ID/EX value.
  - Never forward from a bubble or from a destination of R0.
- Load-use hazard: LW in EX whose rt matches rs or rt of the consumer in ID.
  - Insert exactly one bubble into EX; hold PC and IF/ID.
  - The loaded value is then forwarded from MEM/WB.
- Branches:
  - Resolved in EX.
  - Taken: PC <- target; IF/ID and ID/EX are flushed (valid=0). Penalty is 2 cycles.
  - Not taken: no penalty.
  - A branch consuming a load result stalls per the load-use rule.
- Flushed or bubble instructions cause no register write, no dmem_we and no retire pulse.
- HALT:
  - Decoded in ID: PC freezes and IF/ID becomes a bubble; older instructions drain.
  - If a taken branch in EX flushes the HALT in ID, the HALT is cancelled and fetch resumes at the target.
  - HALT reaching WB:
    - Sets halted=1 at that edge and counts as retired.
    - Thereafter no state changes until reset: dmem_we=0, retire_valid=0.
- dmem_we is asserted combinationally only while a valid SW is in MEM.
- Each cycle with a valid instruction in WB:
  - retire_valid=1 (combinational).
  - retire_count increments at the edge.

Test Plan:
1. Forwarding. Program: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; HALT.
   - Required: R3=30 with no stall cycles.
   - halted rises 8 edges after reset release; retire_count=4.
2. Load-use. Program: ADDI R1,R0,7; SW R1,5(R0); LW R4,5(R0); ADD R5,R4,R4; HALT.
   - Required: dmem_we pulses once with addr=5, data=7.
   - Exactly one bubble inserted; R5=14; retire_count=5.
3. Taken branch. Program: BEQZ R0,+2; ADDI R6,R0,1; ADDI R6,R0,2; ADDI R7,R0,3; HALT.
   - Required: R6=0, R7=3; the two flushed instructions are not counted, so retire_count=3.
4. Not-taken branch. Program: BNEQZ R0,+2; ADDI R6,R0,1; HALT.
   - Required: R6=1; no flush; retire_count=3.
5. R0 and HALT cancellation.
   - ADDI R0,R0,9 then ADD R8,R0,R0 -> R8=0.
   - BEQZ R0,+1 immediately followed by HALT -> HALT cancelled; the instruction at the target executes.
6. Reset mid-run.
   - Stimulus: assert rst_n=0 for 1 cycle while an SW is in MEM.
   - Required: dmem_we drops immediately; all registers read 0; retire_count=0; the program then reruns from PC=0 and gives identical results.

Source files
------------

// File: rtl/pipe5_core_param.sv
// Parametrised 5-stage IF/ID/EX/MEM/WB integer core with EX forwarding, load-use
// interlock, EX-resolved branches with 2-cycle flush, precise HALT and retire counter.

module pipe5_fwd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      src,
  input  logic [XLEN-1:0] id_val,
  input  logic            em_vld,
  input  logic [4:0]      em_dst,
  input  logic [XLEN-1:0] em_val,
  input  logic            wb_vld,
  input  logic [4:0]      wb_dst,
  input  logic [XLEN-1:0] wb_val,
  output logic [XLEN-1:0] opnd
);
  // Youngest producer wins; producers never carry an R0 destination.
  always_comb begin
    opnd = id_val;
    if (em_vld && em_dst == src)      opnd = em_val;
    else if (wb_vld && wb_dst == src) opnd = wb_val;
  end
endmodule

module pipe5_core_param #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               halted,
  output logic               retire_valid,
  output logic [CNT_W-1:0]   retire_count,
  input  logic [4:0]         dbg_raddr,
  output logic [XLEN-1:0]    dbg_rdata
);
  localparam int STAGES = 4;
  localparam logic [5:0] OP_ADD   = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010,
                         OP_OR    = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101,
                         OP_LW    = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010,
                         OP_SUBI  = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                         OP_BEQZ  = 6'b001110, OP_HALT = 6'b111111;

  typedef struct packed {
    logic [5:0]         op;
    logic               rr, ld, st, br, halt, wr;
    logic [4:0]         rs, rt, dst;
    logic [XLEN-1:0]    a, b, imm;
    logic [IMEM_AW-1:0] pc;
  } idex_t;

  typedef struct packed {
    logic            ld, st, halt, wr;
    logic [4:0]      dst;
    logic [XLEN-1:0] alu, sd;
  } exmem_t;

  typedef struct packed {
    logic            halt, wr;
    logic [4:0]      dst;
    logic [XLEN-1:0] val;
  } memwb_t;

  logic [IMEM_AW-1:0] pc, ifid_pc, br_target;
  logic [31:0]        ifid_ir;
  logic [STAGES:1]    vld_pipe;
  logic               fetch_stop;
  idex_t              idex, id_dec;
  exmem_t             exmem, ex_res;
  memwb_t             memwb, mem_res;
  logic [XLEN-1:0]    regs [32];

  // ---------------- ID ----------------
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_rr, id_imm_op, id_uses_rs, id_uses_rt, wb_wr, load_use, br_taken, id_halt;

  assign id_op      = ifid_ir[31:26];
  assign id_rs      = ifid_ir[25:21];
  assign id_rt      = ifid_ir[20:16];
  assign id_rd      = ifid_ir[15:11];
  assign id_rr      = (id_op <= OP_MUL);
  assign id_imm_op  = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
  assign id_uses_rs = id_rr || id_imm_op || id_dec.ld || id_dec.st || id_dec.br;
  assign id_uses_rt = id_rr || id_dec.st;
  assign wb_wr      = vld_pipe[4] && memwb.wr;

  always_comb begin
    id_dec      = '0;
    id_dec.op   = id_op;
    id_dec.rr   = id_rr;
    id_dec.ld   = (id_op == OP_LW);
    id_dec.st   = (id_op == OP_SW);
    id_dec.br   = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
    id_dec.halt = (id_op == OP_HALT);
    id_dec.rs   = id_rs;
    id_dec.rt   = id_rt;
    id_dec.dst  = id_rr ? id_rd : id_rt;
    id_dec.wr   = (id_rr || id_imm_op || id_dec.ld) && (id_dec.dst != 5'd0);
    id_dec.imm  = XLEN'(signed'(ifid_ir[15:0]));
    id_dec.pc   = ifid_pc;
    // Write-through: a WB write in this cycle is visible to the ID read.
    id_dec.a    = (wb_wr && memwb.dst == id_rs) ? memwb.val : regs[id_rs];
    id_dec.b    = (wb_wr && memwb.dst == id_rt) ? memwb.val : regs[id_rt];
  end

  assign load_use = vld_pipe[1] && vld_pipe[2] && idex.ld && idex.wr &&
                    ((id_uses_rs && id_rs == idex.dst) || (id_uses_rt && id_rt == idex.dst));
  assign id_halt  = vld_pipe[1] && id_dec.halt;

  // ---------------- EX ----------------
  logic [1:0][4:0]      ex_src;
  logic [1:0][XLEN-1:0] ex_idv, ex_opnd;
  logic [XLEN-1:0]      ex_b, ex_alu;

  assign ex_src[0] = idex.rs;
  assign ex_src[1] = idex.rt;
  assign ex_idv[0] = idex.a;
  assign ex_idv[1] = idex.b;

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    pipe5_fwd #(.XLEN(XLEN)) u_fwd (
      .src    (ex_src[g]),
      .id_val (ex_idv[g]),
      .em_vld (vld_pipe[3] && exmem.wr && !exmem.ld),
      .em_dst (exmem.dst),
      .em_val (exmem.alu),
      .wb_vld (wb_wr),
      .wb_dst (memwb.dst),
      .wb_val (memwb.val),
      .opnd   (ex_opnd[g])
    );
  end

  assign ex_b = idex.rr ? ex_opnd[1] : idex.imm;

  always_comb begin
    case (idex.op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_alu = ex_opnd[0] + ex_b;
      OP_SUB, OP_SUBI:               ex_alu = ex_opnd[0] - ex_b;
      OP_AND:                        ex_alu = ex_opnd[0] & ex_b;
      OP_OR:                         ex_alu = ex_opnd[0] | ex_b;
      OP_SLT, OP_SLTI:               ex_alu = XLEN'($signed(ex_opnd[0]) < $signed(ex_b));
      OP_MUL:                        ex_alu = ex_opnd[0] * ex_b;
      default:                       ex_alu = '0;
    endcase
  end

  assign br_taken  = vld_pipe[2] && idex.br && ((idex.op == OP_BEQZ) == (ex_opnd[0] == '0));
  assign br_target = idex.pc + 1'b1 + idex.imm[IMEM_AW-1:0];

  always_comb begin
    ex_res      = '0;
    ex_res.ld   = idex.ld;
    ex_res.st   = idex.st;
    ex_res.halt = idex.halt;
    ex_res.wr   = idex.wr;
    ex_res.dst  = idex.dst;
    ex_res.alu  = ex_alu;
    ex_res.sd   = ex_opnd[1];
  end

  // ---------------- MEM / WB ----------------
  assign dmem_addr  = exmem.alu[DMEM_AW-1:0];
  assign dmem_wdata = exmem.sd;
  assign dmem_we    = vld_pipe[3] && exmem.st && !halted;

  always_comb begin
    mem_res      = '0;
    mem_res.halt = exmem.halt;
    mem_res.wr   = exmem.wr;
    mem_res.dst  = exmem.dst;
    mem_res.val  = exmem.ld ? dmem_rdata : exmem.alu;
  end

  assign imem_addr    = pc;
  assign retire_valid = vld_pipe[4] && !halted;
  assign dbg_rdata    = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      ifid_pc      <= '0;
      ifid_ir      <= '0;
      vld_pipe     <= '0;
      fetch_stop   <= 1'b0;
      idex         <= '0;
      exmem        <= '0;
      memwb        <= '0;
      halted       <= 1'b0;
      retire_count <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halted) begin
      if (br_taken) begin
        pc          <= br_target;
        vld_pipe[1] <= 1'b0;
        vld_pipe[2] <= 1'b0;
      end else if (load_use) begin
        vld_pipe[2] <= 1'b0;
      end else begin
        idex        <= id_dec;
        vld_pipe[2] <= vld_pipe[1];
        // A decoded HALT stops fetch for good; only reset restarts it.
        if (id_halt || fetch_stop) begin
          fetch_stop  <= 1'b1;
          vld_pipe[1] <= 1'b0;
        end else begin
          pc          <= pc + 1'b1;
          ifid_pc     <= pc;
          ifid_ir     <= imem_rdata;
          vld_pipe[1] <= 1'b1;
        end
      end
      exmem       <= ex_res;
      vld_pipe[3] <= vld_pipe[2];
      memwb       <= mem_res;
      vld_pipe[4] <= vld_pipe[3];
      if (wb_wr) regs[memwb.dst] <= memwb.val;
      if (vld_pipe[4]) retire_count <= retire_count + 1'b1;
      if (vld_pipe[4] && memwb.halt) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe5_core_param.sv
// Directed programs for pipe5_core_param; store and register-file scoreboards
// filled when each program is loaded, drained as the core produces results.

module tb_pipe5_core_param;
  localparam int XLEN = 32, IMEM_AW = 10, DMEM_AW = 10, CNT_W = 32;
  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03,
                         OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09,
                         OP_ADDI = 6'h0a, OP_SUBI = 6'h0b, OP_SLTI = 6'h0c,
                         OP_BNEQZ = 6'h0d, OP_BEQZ = 6'h0e, OP_HALT = 6'h3f;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [XLEN-1:0]    dmem_wdata, dmem_rdata, dbg_rdata;
  logic               dmem_we, halted, retire_valid;
  logic [CNT_W-1:0]   retire_count;
  logic [4:0]         dbg_raddr = 5'd0;

  logic [31:0]     imem [1024];
  logic [XLEN-1:0] dmem [1024];

  typedef struct { int idx; logic [XLEN-1:0] val; } reg_exp_t;
  typedef struct { logic [DMEM_AW-1:0] addr; logic [XLEN-1:0] data; } st_exp_t;
  reg_exp_t reg_q[$];
  st_exp_t  st_q[$];

  int total = 0, bad = 0, edges = 0, rets = 0, npc = 0;

  pipe5_core_param #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .halted(halted), .retire_valid(retire_valid), .retire_count(retire_count),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = '0;
    npc = 0;
    reg_q.delete();
    st_q.delete();
  endtask

  task automatic put(input logic [31:0] ins);
    imem[npc] = ins;
    npc++;
  endtask

  task automatic exp_reg(input int idx, input logic [XLEN-1:0] val);
    reg_exp_t e;
    e.idx = idx; e.val = val;
    reg_q.push_back(e);
  endtask

  task automatic exp_st(input logic [DMEM_AW-1:0] a, input logic [XLEN-1:0] d);
    st_exp_t e;
    e.addr = a; e.data = d;
    st_q.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    dbg_raddr = 5'd1;
    #1;
    chk({tag, "_rst_halted"}, 64'(halted), 64'd0);
    chk({tag, "_rst_count"}, 64'(retire_count), 64'd0);
    chk({tag, "_rst_rv"}, 64'(retire_valid), 64'd0);
    chk({tag, "_rst_we"}, 64'(dmem_we), 64'd0);
    chk({tag, "_rst_r1"}, 64'(dbg_rdata), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    rets = 0;
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    st_exp_t e;
    @(posedge clk);
    #1;
    edges++;
    if (retire_valid) rets++;
    if (dmem_we) begin
      chk("store_expected", 64'(st_q.size() != 0), 64'd1);
      if (st_q.size() != 0) begin
        e = st_q.pop_front();
        chk("store_addr", 64'(dmem_addr), 64'(e.addr));
        chk("store_data", 64'(dmem_wdata), 64'(e.data));
      end
    end
  endtask

  task automatic run_halt(input string tag, input int exp_edges, input int exp_ret);
    reg_exp_t e;
    for (int i = 0; i < 300 && !halted; i++) step();
    chk({tag, "_halted"}, 64'(halted), 64'd1);
    chk({tag, "_edges"}, 64'(edges), 64'(exp_edges));
    chk({tag, "_retcnt"}, 64'(retire_count), 64'(exp_ret));
    chk({tag, "_retpulses"}, 64'(rets), 64'(exp_ret));
    chk({tag, "_stores_left"}, 64'(st_q.size()), 64'd0);
    while (reg_q.size() != 0) begin
      e = reg_q.pop_front();
      dbg_raddr = 5'(e.idx);
      #1;
      chk($sformatf("%s_r%0d", tag, e.idx), 64'(dbg_rdata), 64'(e.val));
    end
    repeat (3) step();
    chk({tag, "_frozen_cnt"}, 64'(retire_count), 64'(exp_ret));
    chk({tag, "_frozen_rv"}, 64'(rets), 64'(exp_ret));
  endtask

  initial begin
    // 1: forwarding, no stalls
    clear_prog();
    put(enc_i(OP_ADDI, 1, 0, 10));
    put(enc_i(OP_ADDI, 2, 0, 20));
    put(enc_r(OP_ADD, 3, 1, 2));
    put({OP_HALT, 26'd0});
    exp_reg(1, 10); exp_reg(2, 20); exp_reg(3, 30);
    do_reset("t1");
    run_halt("t1", 8, 4);

    // 2: store, load-use bubble
    clear_prog();
    put(enc_i(OP_ADDI, 1, 0, 7));
    put(enc_i(OP_SW, 1, 0, 5));
    put(enc_i(OP_LW, 4, 0, 5));
    put(enc_r(OP_ADD, 5, 4, 4));
    put({OP_HALT, 26'd0});
    exp_st(5, 7);
    exp_reg(4, 7); exp_reg(5, 14);
    do_reset("t2");
    run_halt("t2", 10, 5);

    // 3: taken branch flushes two
    clear_prog();
    put(enc_i(OP_BEQZ, 0, 0, 2));
    put(enc_i(OP_ADDI, 6, 0, 1));
    put(enc_i(OP_ADDI, 6, 0, 2));
    put(enc_i(OP_ADDI, 7, 0, 3));
    put({OP_HALT, 26'd0});
    exp_reg(6, 0); exp_reg(7, 3);
    do_reset("t3");
    run_halt("t3", 9, 3);

    // 4: not-taken branch
    clear_prog();
    put(enc_i(OP_BNEQZ, 0, 0, 2));
    put(enc_i(OP_ADDI, 6, 0, 1));
    put({OP_HALT, 26'd0});
    exp_reg(6, 1);
    do_reset("t4");
    run_halt("t4", 7, 3);

    // 5a: R0 ignores writes
    clear_prog();
    put(enc_i(OP_ADDI, 0, 0, 9));
    put(enc_r(OP_ADD, 8, 0, 0));
    put({OP_HALT, 26'd0});
    exp_reg(0, 0); exp_reg(8, 0);
    do_reset("t5a");
    run_halt("t5a", 7, 3);

    // 5b: HALT in the branch shadow is cancelled
    clear_prog();
    put(enc_i(OP_BEQZ, 0, 0, 1));
    put({OP_HALT, 26'd0});
    put(enc_i(OP_ADDI, 10, 0, 5));
    put({OP_HALT, 26'd0});
    exp_reg(10, 5);
    do_reset("t5b");
    run_halt("t5b", 9, 3);

    // 7: ALU op coverage with signed values
    clear_prog();
    put(enc_i(OP_ADDI, 1, 0, -3));
    put(enc_i(OP_ADDI, 2, 0, 5));
    put(enc_r(OP_MUL, 3, 1, 2));
    put(enc_r(OP_SUB, 4, 2, 1));
    put(enc_r(OP_SLT, 5, 1, 2));
    put(enc_i(OP_SLTI, 6, 1, -1));
    put(enc_r(OP_AND, 7, 2, 3));
    put(enc_r(OP_OR, 8, 1, 2));
    put(enc_i(OP_SUBI, 9, 2, 7));
    put({OP_HALT, 26'd0});
    exp_reg(3, 32'hFFFF_FFF1); exp_reg(4, 8); exp_reg(5, 1); exp_reg(6, 1);
    exp_reg(7, 1); exp_reg(8, 32'hFFFF_FFFD); exp_reg(9, 32'hFFFF_FFFE);
    do_reset("t7");
    run_halt("t7", 14, 10);

    // 6: reset while the SW sits in MEM, then a clean rerun
    clear_prog();
    put(enc_i(OP_ADDI, 1, 0, 7));
    put(enc_i(OP_ADDI, 2, 0, 3));
    put(enc_i(OP_ADDI, 3, 0, 4));
    put(enc_i(OP_ADDI, 9, 0, 1));
    put(enc_i(OP_SW, 1, 0, 5));
    put(enc_i(OP_LW, 4, 0, 5));
    put(enc_r(OP_ADD, 5, 4, 2));
    put({OP_HALT, 26'd0});
    exp_st(5, 7);
    do_reset("t6a");
    repeat (7) step();
    chk("t6_we_pre", 64'(dmem_we), 64'd1);
    chk("t6_cnt_pre", 64'(retire_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_we_rst", 64'(dmem_we), 64'd0);
    chk("t6_cnt_rst", 64'(retire_count), 64'd0);
    chk("t6_rv_rst", 64'(retire_valid), 64'd0);
    for (int r = 1; r < 10; r++) begin
      dbg_raddr = 5'(r);
      #1;
      chk($sformatf("t6_rst_r%0d", r), 64'(dbg_rdata), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    rets = 0;
    exp_st(5, 7);
    exp_reg(1, 7); exp_reg(2, 3); exp_reg(3, 4); exp_reg(9, 1); exp_reg(4, 7); exp_reg(5, 10);
    run_halt("t6b", 13, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
